// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation encodings and the
// record held per queued instruction.
package alu_pkg;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } aluctr_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic        use_imm;
    aluctr_e     aluctr;
    logic        illegal;
  } issue_entry_t;

  localparam int unsigned EntryWidth = $bits(issue_entry_t);

endpackage

// File: rtl/alu_issue_fifo.sv
// Two-deep queue of decoded issue entries. Head is read combinationally from
// registered storage, so there is no path from the write side to the read side.
module alu_issue_fifo
  import alu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  issue_entry_t wdata_i,
  input  logic         pop_i,
  output issue_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  issue_entry_t mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  // A push into a full queue is refused even if a pop happens the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Storage, pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the ALU operation at capture, queues up to two
// instructions and presents the head with forwarded operands.
// Build option ALU_ISSUE_FWD_EN: when defined, head sources are forwarded from
// the EX/MEM and MEM/WB writers; when undefined, the head is held back
// (out_valid=0) while any used non-x0 source matches an active writer.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rdata1,
  input  logic [31:0] in_rdata2,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic        in_rtype,
  input  logic        exm_wen,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_wdata,
  input  logic        mwb_wen,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_wdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  aluctr,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  issue_entry_t new_entry, head;
  logic         full, empty, push, pop, stall;
  logic [31:0]  src1, src2;

  // Writer wen/rd matches a non-x0 source register.
  function automatic logic hits(input logic wen, input logic [4:0] wrd, input logic [4:0] rs);
    return wen && (wrd == rs) && (rs != 5'd0);
  endfunction

  // Decode the ALU operation and pack the incoming instruction.
  always_comb begin
    new_entry         = '0;
    new_entry.rs1     = in_rs1;
    new_entry.rs2     = in_rs2;
    new_entry.rd      = in_rd;
    new_entry.rdata1  = in_rdata1;
    new_entry.rdata2  = in_rdata2;
    new_entry.imm     = in_imm;
    new_entry.use_imm = in_use_imm;
    new_entry.aluctr  = AluAdd;
    new_entry.illegal = 1'b0;
    case (in_funct3)
      3'b000:  new_entry.aluctr = (in_rtype && in_funct7_5) ? AluSub : AluAdd;
      3'b111:  new_entry.aluctr = AluAnd;
      3'b110:  new_entry.aluctr = AluOr;
      3'b010:  new_entry.aluctr = AluSlt;
      default: new_entry.illegal = 1'b1;
    endcase
  end

  // in_ready is low throughout reset and depends only on registered occupancy.
  assign in_ready  = rst_n && !full;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty && !stall;
  assign pop       = out_valid && out_ready;

  alu_issue_fifo u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (new_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef ALU_ISSUE_FWD_EN
  // Forward head sources; EX/MEM wins over MEM/WB.
  always_comb begin
    src1 = head.rdata1;
    src2 = head.rdata2;
    if (hits(exm_wen, exm_rd, head.rs1))      src1 = exm_wdata;
    else if (hits(mwb_wen, mwb_rd, head.rs1)) src1 = mwb_wdata;
    if (hits(exm_wen, exm_rd, head.rs2))      src2 = exm_wdata;
    else if (hits(mwb_wen, mwb_rd, head.rs2)) src2 = mwb_wdata;
  end
  assign stall = 1'b0;
`else
  logic unused_wdata;
  assign unused_wdata = ^{exm_wdata, mwb_wdata};

  // No forwarding: hold the head while a used source is still being written.
  always_comb begin
    src1  = head.rdata1;
    src2  = head.rdata2;
    stall = hits(exm_wen, exm_rd, head.rs1) || hits(mwb_wen, mwb_rd, head.rs1);
    if (!head.use_imm) begin
      stall = stall || hits(exm_wen, exm_rd, head.rs2) || hits(mwb_wen, mwb_rd, head.rs2);
    end
  end
`endif

  // Head outputs, zeroed whenever nothing valid is presented.
  always_comb begin
    a           = '0;
    b           = '0;
    aluctr      = '0;
    out_rd      = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      a           = src1;
      b           = head.use_imm ? head.imm : src2;
      aluctr      = head.aluctr;
      out_rd      = head.rd;
      out_illegal = head.illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue stage.
module tb_alu_issue;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] r1, r2, imm;
    logic        use_imm, rtype, f75;
    logic [2:0]  f3;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd, out_rd;
  logic [31:0] exm_wdata, mwb_wdata, a, b;
  logic [2:0]  aluctr;
  instr_t      cur;
  instr_t      q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (cur.rs1),
    .in_rs2      (cur.rs2),
    .in_rd       (cur.rd),
    .in_rdata1   (cur.r1),
    .in_rdata2   (cur.r2),
    .in_imm      (cur.imm),
    .in_use_imm  (cur.use_imm),
    .in_funct3   (cur.f3),
    .in_funct7_5 (cur.f75),
    .in_rtype    (cur.rtype),
    .exm_wen     (exm_wen),
    .exm_rd      (exm_rd),
    .exm_wdata   (exm_wdata),
    .mwb_wen     (mwb_wen),
    .mwb_rd      (mwb_rd),
    .mwb_wdata   (mwb_wdata),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a           (a),
    .b           (b),
    .aluctr      (aluctr),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writing(input logic [4:0] rs);
    return rs != 0 && ((exm_wen && exm_rd == rs) || (mwb_wen && mwb_rd == rs));
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] stored);
`ifdef ALU_ISSUE_FWD_EN
    if (rs != 0 && exm_wen && exm_rd == rs) return exm_wdata;
    if (rs != 0 && mwb_wen && mwb_rd == rs) return mwb_wdata;
`endif
    return stored;
  endfunction

  function automatic bit stalled(input instr_t h);
`ifdef ALU_ISSUE_FWD_EN
    return 1'b0;
`else
    return writing(h.rs1) || (!h.use_imm && writing(h.rs2));
`endif
  endfunction

  // {illegal, op}: ADD=2, SUB=6, AND=0, OR=1, SLT=7
  function automatic logic [3:0] op_of(input instr_t i);
    case (i.f3)
      3'd0:    return (i.rtype && i.f75) ? 4'd6 : 4'd2;
      3'd7:    return 4'd0;
      3'd6:    return 4'd1;
      3'd2:    return 4'd7;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic bit exp_ov();
    if (q.size() == 0) return 1'b0;
    return !stalled(q[0]);
  endfunction

  task automatic compare();
    instr_t     h;
    logic [3:0] op;
    bit         ov;
    ov = exp_ov();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, ov);
    if (ov) begin
      h  = q[0];
      op = op_of(h);
      check("a", a, src_val(h.rs1, h.r1));
      check("b", b, h.use_imm ? h.imm : src_val(h.rs2, h.r2));
      check("aluctr", aluctr, op[2:0]);
      check("illegal", out_illegal, op[3]);
      check("out_rd", out_rd, h.rd);
    end else begin
      check("idle ops", {a ^ b, 27'd0, out_rd}, 64'd0);
      check("idle ctl", {aluctr, out_illegal}, 4'd0);
    end
  endtask

  // Called just after a rising edge; applies one cycle of input and advances the model.
  task automatic step(input logic v, input logic ordy, input logic fl);
    bit psh, pp;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    compare();
    psh = v && q.size() < 2;
    pp  = exp_ov() && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(cur);
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.rs1     = 5'($urandom_range(0, 3));
    i.rs2     = 5'($urandom_range(0, 3));
    i.rd      = 5'($urandom_range(0, 31));
    i.r1      = (i.rs1 == 0) ? 32'd0 : $urandom;
    i.r2      = (i.rs2 == 0) ? 32'd0 : $urandom;
    i.imm     = $urandom;
    i.use_imm = 1'($urandom_range(0, 1));
    i.rtype   = 1'($urandom_range(0, 1));
    i.f75     = 1'($urandom_range(0, 1));
    i.f3      = 3'($urandom_range(0, 7));
    return i;
  endfunction

  task automatic writers_off();
    exm_wen = 0; exm_rd = 0; exm_wdata = 0;
    mwb_wen = 0; mwb_rd = 0; mwb_wdata = 0;
  endtask

  initial begin
    cur = '{default: '0};
    writers_off();
    in_valid = 0; out_ready = 0; flush = 0; rst_n = 0;
    @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    in_valid = 1;
    #1;
    check("reset no accept", in_ready, 0);
    in_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;

    // Back-to-back issue
    for (int k = 0; k < 3; k++) begin
      cur = '{default: '0};
      cur.rs1 = 1; cur.rs2 = 2; cur.rd = 5'(4 + k); cur.rtype = 1;
      cur.r1 = 32'(5 + 10 * k); cur.r2 = 32'(7 + 10 * k);
      step(1, 1, 0);
      check("b2b valid", out_valid, 1);
      check("b2b a", a, 32'(5 + 10 * k));
      check("b2b b", b, 32'(7 + 10 * k));
      check("b2b aluctr", aluctr, 3'b010);
    end
    step(0, 1, 0);

    // Forwarding priority (stall in the non-forwarding build)
    cur = '{default: '0};
    cur.rs1 = 3; cur.r1 = 32'h33; cur.use_imm = 1; cur.imm = 32'h44; cur.f3 = 3'd7;
    step(1, 0, 0);
    in_valid = 0;
    exm_wen = 1; exm_rd = 3; exm_wdata = 32'h11;
    mwb_wen = 1; mwb_rd = 3; mwb_wdata = 32'h22;
    #1;
`ifdef ALU_ISSUE_FWD_EN
    check("fwd exm a", a, 32'h11);
    exm_wen = 0; #1;
    check("fwd mwb a", a, 32'h22);
`else
    check("hazard hold", out_valid, 0);
    exm_wen = 0; #1;
    check("hazard mwb hold", out_valid, 0);
`endif
    mwb_wen = 0; #1;
    check("fwd none a", a, 32'h33);
    check("imm b", b, 32'h44);
    step(0, 1, 0);

    // x0 never forwarded
    cur = '{default: '0};
    exm_wen = 1; exm_rd = 0; exm_wdata = 32'hFF;
    step(1, 0, 0);
    check("x0 valid", out_valid, 1);
    check("x0 b", b, 0);
    writers_off();
    step(0, 1, 0);

    // Backpressure: third push held, head unchanged
    for (int k = 0; k < 3; k++) begin
      cur = '{default: '0};
      cur.rd = 5'(10 + k); cur.rs1 = 5'(1 + k); cur.r1 = 32'(100 + k);
      step(1, 0, 0);
      if (k == 1) check("bp full", in_ready, 0);
    end
    check("bp head rd", out_rd, 10);
    check("bp head a", a, 100);
    check("bp still full", in_ready, 0);

    // Flush with concurrent push
    cur.rd = 13;
    step(1, 1, 1);
    check("flush valid", out_valid, 0);
    check("flush ready", in_ready, 1);
    step(0, 1, 0);

    // Decode
    cur = '{default: '0};
    cur.f3 = 3'd0; cur.rtype = 1; cur.f75 = 1;
    step(1, 0, 0);
    check("dec sub", aluctr, 3'b110);
    check("dec sub legal", out_illegal, 0);
    cur.f3 = 3'd4; cur.rtype = 0;
    step(1, 1, 0);
    check("dec illegal op", aluctr, 3'b010);
    check("dec illegal", out_illegal, 1);
    step(0, 1, 0);

    // Random traffic with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      cur       = rand_instr();
      exm_wen   = 1'($urandom_range(0, 1));
      exm_rd    = 5'($urandom_range(0, 3));
      exm_wdata = $urandom;
      mwb_wen   = 1'($urandom_range(0, 1));
      mwb_rd    = 5'($urandom_range(0, 3));
      mwb_wdata = $urandom;
      if (i == 200) begin
        in_valid = 1;
        #2 rst_n = 0;
        #1;
        check("midrst in_ready", in_ready, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst a", a, 0);
        q.delete();
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
      end
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
